// File: rtl/prog_loader.sv
// Purpose : boot loader that takes a host byte stream (count, then LO/HI byte
//           pairs per instruction) and writes the words into instruction memory,
//           then releases the core. Optional macro: LOADER_CHECKSUM_EN adds a
//           trailing checksum byte that must match the 8-bit sum of all LO/HI bytes.
// Latency : one imem write per accepted HI byte, one cycle after it; core_run
//           rises the cycle after the last write (or after the checksum byte).
// Backpressure: in_ready is low during WRITE, RUN and ERR; a host that holds
//           in_valid low stalls the loader with no state change.
// Ports   : clk, reset (async active-low), in_data/in_valid/in_ready (byte
//           stream), reload, imem_we/imem_addr/imem_wdata (memory write port),
//           core_run, error (sticky), loaded_count.
module prog_loader #(
    parameter int AW = 8,
    parameter int IW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          reload,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [IW-1:0] imem_wdata,
    output logic          core_run,
    output logic          error,
    output logic [AW:0]   loaded_count
);

    typedef enum logic [2:0] {
        S_COUNT = 3'd0,
        S_LO    = 3'd1,
        S_HI    = 3'd2,
        S_WRITE = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        S_CHK   = 3'd6,
`endif
        S_RUN   = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [AW:0] MAX_N = {1'b1, {AW{1'b0}}};

    state_t        state_q, state_d;
    logic [AW:0]   n_q, n_d;
    logic [AW:0]   index_q, index_d;
    logic [7:0]    lo_q, lo_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [IW-1:0] wdata_q, wdata_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          in_ready_q, in_ready_d;
    logic          we_q, we_d;
    logic          run_q, run_d;
    logic          err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    sum_q, sum_d;
`endif

    logic          take;
    logic [8:0]    count_raw;
    logic [AW:0]   count_n;
    logic [AW:0]   index_inc;
    logic          hi_bad;
    logic [IW-1:0] word;

    assign take      = in_valid && in_ready_q;
    // A count byte of zero stands for 256 instructions.
    assign count_raw = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
    // Never ask for more words than the memory can hold.
    assign count_n   = (32'(count_raw) > 32'(MAX_N)) ? MAX_N : (AW+1)'(count_raw);
    assign index_inc = index_q + (AW+1)'(1);
    // Any HI-byte bit above the instruction width marks a malformed stream.
    assign hi_bad    = |(in_data >> (IW - 8));
    assign word      = IW'({in_data, lo_q});

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        index_d = index_q;
        lo_d    = lo_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            S_COUNT: begin
                if (take) begin
                    n_d     = count_n;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (take) begin
                    lo_d    = in_data;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = sum_q + in_data;
`endif
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (take) begin
`ifdef LOADER_CHECKSUM_EN
                    sum_d = sum_q + in_data;
`endif
                    if (hi_bad) begin
                        state_d = S_ERR;
                    end else begin
                        addr_d  = index_q[AW-1:0];
                        wdata_d = word;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                index_d = index_inc;
                cnt_d   = index_inc;
                if (index_inc < n_q) begin
                    state_d = S_LO;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_RUN;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (take) begin
                    state_d = (in_data == sum_q) ? S_RUN : S_ERR;
                end
            end
`endif
            S_RUN, S_ERR: begin
                if (reload) begin
                    state_d = S_COUNT;
                    index_d = '0;
                    cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            default: begin
                state_d = S_COUNT;
            end
        endcase

        // Output flags are a function of the next state and are registered,
        // so they line up with the state they describe.
        in_ready_d = (state_d == S_COUNT) || (state_d == S_LO) || (state_d == S_HI);
`ifdef LOADER_CHECKSUM_EN
        if (state_d == S_CHK) begin
            in_ready_d = 1'b1;
        end
`endif
        we_d  = (state_d == S_WRITE);
        run_d = (state_d == S_RUN);
        err_d = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_COUNT;
            n_q        <= '0;
            index_q    <= '0;
            lo_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            run_q      <= 1'b0;
            err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            index_q    <= index_d;
            lo_q       <= lo_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            run_q      <= run_d;
            err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign core_run     = run_q;
    assign error        = err_q;
    assign loaded_count = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       reload;
    logic       imem_we;
    logic [7:0] imem_addr;
    logic [8:0] imem_wdata;
    logic       core_run;
    logic       error;
    logic [8:0] loaded_count;

    prog_loader #(.AW(8), .IW(9)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .reload(reload), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_run(core_run),
        .error(error), .loaded_count(loaded_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [8:0] data;
        int         cyc;
    } wr_t;

    typedef struct packed {
        logic [3:0]  nb;
        logic [63:0] bytes;
        logic [2:0]  nw;
        logic [35:0] words;
        logic        err;
        logic [8:0]  cnt;
        logic        mid_reload;
        logic        stall;
    } vec_t;

    wr_t  wq[$];
    int   cyc = 0;
    int   run_cyc = 0;
    logic run_prev = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) wq.push_back('{imem_addr, imem_wdata, cyc});
        if (core_run && !run_prev) run_cyc <= cyc;
        run_prev <= core_run;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  guard = 0;
        bit  done  = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!done && guard < 64) begin
            @(negedge clk);
            guard++;
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        in_valid = 1'b0;
        if (!done) chk("send_byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        chk("reload_core_run", 32'(core_run), 32'd0);
        chk("reload_error", 32'(error), 32'd0);
        chk("reload_in_ready", 32'(in_ready), 32'd1);
        chk("reload_loaded_count", 32'(loaded_count), 32'd0);
    endtask

    task automatic wait_done();
        for (int g = 0; g < 20 && !(core_run || error); g++) @(negedge clk);
        #1;
    endtask

    vec_t vecs[5];

    initial begin
        reset    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        reload   = 1'b0;

        vecs[0] = '{nb:4'd5, bytes:64'h00_12_01_34_02, nw:3'd2,
                    words:{18'h0, 9'h012, 9'h134}, err:1'b0, cnt:9'd2,
                    mid_reload:1'b0, stall:1'b0};
        vecs[1] = '{nb:4'd3, bytes:64'h00_FF_01, nw:3'd1,
                    words:{27'h0, 9'h0FF}, err:1'b0, cnt:9'd1,
                    mid_reload:1'b0, stall:1'b0};
        vecs[2] = '{nb:4'd3, bytes:64'h02_05_01, nw:3'd0,
                    words:36'h0, err:1'b1, cnt:9'd0,
                    mid_reload:1'b0, stall:1'b0};
        vecs[3] = '{nb:4'd7, bytes:64'h01_00_00_55_01_AA_03, nw:3'd3,
                    words:{9'h0, 9'h100, 9'h055, 9'h1AA}, err:1'b0, cnt:9'd3,
                    mid_reload:1'b1, stall:1'b1};
        vecs[4] = '{nb:4'd5, bytes:64'h80_88_01_77_02, nw:3'd1,
                    words:{27'h0, 9'h177}, err:1'b1, cnt:9'd0,
                    mid_reload:1'b0, stall:1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_imem_wdata", 32'(imem_wdata), 32'd0);
        chk("rst_core_run", 32'(core_run), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_loaded_count", 32'(loaded_count), 32'd0);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);

        // Table-driven loads
        for (int i = 0; i < 5; i++) begin
            pulse_reload();
            wq.delete();
            send_byte(vecs[i].bytes[7:0]);
            if (vecs[i].mid_reload) pulse_reload();
            for (int k = 1; k < int'(vecs[i].nb); k++) begin
                if (vecs[i].stall) idle($urandom_range(0, 3));
                send_byte(vecs[i].bytes[8*k +: 8]);
            end
            wait_done();
            chk($sformatf("v%0d_nwrites", i), 32'(wq.size()), 32'(vecs[i].nw));
            for (int k = 0; k < int'(vecs[i].nw) && k < wq.size(); k++) begin
                chk($sformatf("v%0d_w%0d_addr", i, k), 32'(wq[k].addr), 32'(k));
                chk($sformatf("v%0d_w%0d_data", i, k), 32'(wq[k].data),
                    32'(vecs[i].words[9*k +: 9]));
            end
            chk($sformatf("v%0d_error", i), 32'(error), 32'(vecs[i].err));
            chk($sformatf("v%0d_core_run", i), 32'(core_run), 32'(!vecs[i].err));
            if (!vecs[i].err) begin
                chk($sformatf("v%0d_loaded_count", i), 32'(loaded_count), 32'(vecs[i].cnt));
                if (wq.size() > 0)
                    chk($sformatf("v%0d_run_timing", i), 32'(run_cyc), 32'(wq[wq.size()-1].cyc + 1));
            end
        end

        // Full 256-instruction load (count byte 0)
        pulse_reload();
        wq.delete();
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            logic [8:0] iv;
            iv = 9'(i);
            send_byte(iv[7:0]);
            send_byte({7'd0, iv[0]});
        end
        wait_done();
        chk("full_nwrites", 32'(wq.size()), 32'd256);
        for (int i = 0; i < 256 && i < wq.size(); i++) begin
            logic [8:0] iv;
            iv = 9'(i);
            chk($sformatf("full_w%0d", i), {15'd0, wq[i].addr, wq[i].data},
                {15'd0, iv[7:0], iv[0], iv[7:0]});
        end
        chk("full_loaded_count", 32'(loaded_count), 32'd256);
        chk("full_core_run", 32'(core_run), 32'd1);

        // Bytes offered in RUN are neither accepted nor acted on
        in_data  = 8'hAB;
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("run_in_ready", 32'(in_ready), 32'd0);
        chk("run_core_run_held", 32'(core_run), 32'd1);
        chk("run_no_write", 32'(wq.size()), 32'd256);
        in_valid = 1'b0;

`ifdef LOADER_CHECKSUM_EN
        pulse_reload();
        send_byte(8'h01); send_byte(8'h10); send_byte(8'h01); send_byte(8'h11);
        wait_done();
        chk("csum_good_run", 32'(core_run), 32'd1);
        chk("csum_good_err", 32'(error), 32'd0);
        pulse_reload();
        send_byte(8'h01); send_byte(8'h10); send_byte(8'h01); send_byte(8'h12);
        wait_done();
        chk("csum_bad_err", 32'(error), 32'd1);
        chk("csum_bad_run", 32'(core_run), 32'd0);
`endif

        // Reset asserted while a write is in flight
        pulse_reload();
        wq.delete();
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h00);
        reset = 1'b0;
        #1;
        chk("midrst_imem_we", 32'(imem_we), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_imem_addr", 32'(imem_addr), 32'd0);
        repeat (3) @(negedge clk);
        chk("midrst_no_writes", 32'(wq.size()), 32'd0);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready_back", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The module SHALL have parameter AW, default 8: the instruction memory address width.
REQ-002 The module SHALL have parameter IW, default 9: the instruction width in bits, with IW-8 <= 8.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port in_data, input, 8 bits: host byte stream.
REQ-006 The module SHALL have port in_valid, input, 1 bit: host asserts when in_data holds a byte.
REQ-007 The module SHALL have port in_ready, output, 1 bit: the loader accepts the byte; a transfer occurs when in_valid and in_ready are both high on a clk edge.
REQ-008 The module SHALL have port reload, input, 1 bit: request a new program load.
REQ-009 The module SHALL have port imem_we, output, 1 bit: instruction memory write strobe.
REQ-010 The module SHALL have port imem_addr, output, AW bits: instruction memory write address.
REQ-011 The module SHALL have port imem_wdata, output, IW bits: instruction word to write.
REQ-012 The module SHALL have port core_run, output, 1 bit: processor released; low holds the core in reset.
REQ-013 The module SHALL have port error, output, 1 bit: load failed (sticky).
REQ-014 The module SHALL have port loaded_count, output, AW+1 bits: number of instructions written in the last load.

Function
REQ-015 The loader SHALL implement the states COUNT, LO, HI, WRITE, CHK, RUN and ERR, all with registered outputs.
REQ-016 In COUNT, in_ready SHALL be 1, and the accepted byte SHALL give N = byte, with byte 0 meaning N = 256 (capped to 2^AW); next state is LO.
REQ-017 In LO, in_ready SHALL be 1, and the accepted byte SHALL be stored as instruction bits [7:0]; next state is HI.
REQ-018 In HI, in_ready SHALL be 1, and bits [IW-9:0] of the accepted byte SHALL supply instruction bits [IW-1:8]; if any higher bit of the byte is 1, next state is ERR, otherwise WRITE.
REQ-019 In WRITE, imem_we SHALL be 1 for exactly one cycle with imem_addr = current index and imem_wdata = assembled word, and in_ready SHALL be 0.
REQ-020 After WRITE, the index SHALL increment, and the next state SHALL be LO if index < N, else CHK (when checksum is enabled) or RUN.
REQ-021 Addresses SHALL start at 0 and increment by 1 with no wrap; N = 2^AW ends exactly at address 2^AW-1.
REQ-022 On entry to RUN, loaded_count SHALL equal N.
REQ-023 In RUN, core_run SHALL be 1, and in_ready and imem_we SHALL be 0; bytes presented in RUN SHALL be ignored, not consumed.
REQ-024 In ERR, error SHALL be 1, core_run SHALL be 0 and in_ready SHALL be 0.
REQ-025 reload sampled high in RUN or ERR SHALL move the loader to COUNT on the next edge.
REQ-026 On a reload, core_run and error SHALL drop to 0 in that same next-edge cycle, index SHALL clear to 0 and loaded_count SHALL clear to 0.
REQ-027 reload in any other state SHALL be ignored.
REQ-028 A stalled host (in_valid low) SHALL leave the state and all registers unchanged indefinitely.
REQ-029 imem_we SHALL never be asserted outside WRITE.

Reset
REQ-030 While reset is low, the outputs SHALL be forced: state = COUNT, in_ready = 0, imem_we = 0, imem_addr = 0, imem_wdata = 0, core_run = 0, error = 0, loaded_count = 0, index = 0, checksum = 0.
REQ-031 in_ready SHALL rise on the first clk edge after reset is released.
REQ-032 Reset asserted mid-load SHALL abandon the load, with no further memory writes after the asynchronous assertion.

Configuration
REQ-033 With LOADER_CHECKSUM_EN defined, the loader SHALL keep an 8-bit sum (mod 256) of all LO and HI bytes.
REQ-034 With LOADER_CHECKSUM_EN defined, CHK SHALL accept one byte with in_ready = 1; if that byte equals the sum, next state is RUN, otherwise ERR.
REQ-035 With LOADER_CHECKSUM_EN defined, the sum SHALL clear on entry to COUNT, and the count byte SHALL NOT be summed.
REQ-036 With LOADER_CHECKSUM_EN undefined, the CHK state and sum register SHALL be absent, and WRITE of the last word SHALL go directly to RUN.

Verification
REQ-037 The bench SHALL load bytes 02, 34, 01, 12, 00 (no checksum) and check: writes addr0 = 0x134 and addr1 = 0x012, then core_run = 1 the cycle after the second imem_we, with loaded_count = 2.
REQ-038 The bench SHALL send count 01, then LO 05, then HI 02, and check: error = 1, no imem_we, core_run = 0.
REQ-039 The bench SHALL send count 00 with AW = 8 and 512 payload bytes, and check: 256 writes to addresses 0..255, loaded_count = 256, no address wrap.
REQ-040 The bench SHALL toggle in_valid randomly during a 3-instruction load and check: the same three writes occur and no byte is lost or duplicated.
REQ-041 The bench SHALL pulse reload in RUN and then reload a 1-instruction program 01, FF, 00, and check: core_run drops next cycle, addr0 = 0x0FF, core_run rises again.
REQ-042 With LOADER_CHECKSUM_EN defined, the bench SHALL load 01, 10, 01 followed by checksum 11, expecting core_run = 1, and the same load with checksum 12, expecting error = 1.
